// File: rtl/hms_timer_core.sv
// hh:mm:ss timekeeping core: clock, stopwatch, countdown and alarm-set modes,
// BCD time registers, synchronised button edges and blinking active-low 7-seg decode.
module hms_timer_core #(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned TICK_HZ  = 1,
  parameter int unsigned HOUR_MAX = 24,
  parameter int unsigned BLINK_HZ = 2
) (
  input  logic       CLK,
  input  logic       clr,
  input  logic       start,
  input  logic       pause,
  input  logic [1:0] mode,
  input  logic       adj_sec,
  input  logic       adj_min,
  input  logic       adj_hou,
  input  logic       alarm_ack,
  output logic       timing,
  output logic       alarm,
  output logic       done,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  localparam int unsigned TICK_DIV  = CLK_HZ / TICK_HZ;
  localparam int unsigned BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned TW        = $clog2(TICK_DIV);
  localparam int unsigned BW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned HOUR_LIM  = HOUR_MAX - 1;
  localparam logic [7:0]  HOUR_LAST = {4'(HOUR_LIM / 10), 4'(HOUR_LIM % 10)};

  localparam logic [1:0] MODE_CLOCK = 2'b00;
  localparam logic [1:0] MODE_STOPW = 2'b01;
  localparam logic [1:0] MODE_DOWN  = 2'b10;
  localparam logic [1:0] MODE_ALSET = 2'b11;

  // Two-digit BCD field helpers; no carry/borrow out, callers detect 59/00 themselves.
  function automatic logic [7:0] wrap60(input logic [7:0] v);
    logic [7:0] r;
    r = {v[7:4], v[3:0] + 4'd1};
    if (v == 8'h59)          r = 8'h00;
    else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    return r;
  endfunction

  function automatic logic [7:0] dn60(input logic [7:0] v);
    logic [7:0] r;
    r = {v[7:4], v[3:0] - 4'd1};
    if (v == 8'h00)          r = 8'h59;
    else if (v[3:0] == 4'd0) r = {v[7:4] - 4'd1, 4'd9};
    return r;
  endfunction

  function automatic logic [7:0] inc_hour(input logic [7:0] v);
    logic [7:0] r;
    r = {v[7:4], v[3:0] + 4'd1};
    if (v == HOUR_LAST)      r = 8'h00;
    else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    return r;
  endfunction

  function automatic logic [7:0] dec_hour(input logic [7:0] v);
    logic [7:0] r;
    r = {v[7:4], v[3:0] - 4'd1};
    if (v == 8'h00)          r = 8'h00;
    else if (v[3:0] == 4'd0) r = {v[7:4] - 4'd1, 4'd9};
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'd0:    r = 7'b1000000;
      4'd1:    r = 7'b1111001;
      4'd2:    r = 7'b0100100;
      4'd3:    r = 7'b0110000;
      4'd4:    r = 7'b0011001;
      4'd5:    r = 7'b0010010;
      4'd6:    r = 7'b0000010;
      4'd7:    r = 7'b1111000;
      4'd8:    r = 7'b0000000;
      4'd9:    r = 7'b0010000;
      default: r = 7'b1111111;
    endcase
    return r;
  endfunction

  logic [5:0]    btn, btn_edge;
  logic [5:0]    sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic          e_start, e_pause, e_sec, e_min, e_hou, e_ack;
  logic [23:0]   time_q, time_d, alarm_reg_q, alarm_reg_d;
  logic [23:0]   up_time, dn_time, adj_src, adj_res, disp;
  logic          run_q, run_d, alarm_q, alarm_d, done_q, done_d;
  logic          blink_off_q, blink_off_d;
  logic [1:0]    mode_q, mode_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          tick_c, time_zero_c, mode_chg_c, adj_ok_c, match_c, hit_zero_c, blank_c;
  logic          s_wrap_c, m_wrap_c, s_brw_c, m_brw_c;

  assign btn      = {alarm_ack, adj_hou, adj_min, adj_sec, pause, start};
  assign btn_edge = sync2_q & ~prev_q;
  assign {e_ack, e_hou, e_min, e_sec, e_pause, e_start} = btn_edge;

  assign tick_c      = run_q && (tick_cnt_q == TW'(TICK_DIV - 1));
  assign time_zero_c = (time_q == 24'h0);
  assign mode_chg_c  = (mode != mode_q);
  assign adj_ok_c    = !run_q && (e_sec || e_min || e_hou);

  // Ripple carry/borrow across all three fields in a single cycle.
  assign s_wrap_c = (time_q[7:0] == 8'h59);
  assign m_wrap_c = (time_q[15:8] == 8'h59);
  assign s_brw_c  = (time_q[7:0] == 8'h00);
  assign m_brw_c  = (time_q[15:8] == 8'h00);
  assign up_time  = {(s_wrap_c && m_wrap_c) ? inc_hour(time_q[23:16]) : time_q[23:16],
                     s_wrap_c ? wrap60(time_q[15:8]) : time_q[15:8],
                     wrap60(time_q[7:0])};
  assign dn_time  = {(s_brw_c && m_brw_c) ? dec_hour(time_q[23:16]) : time_q[23:16],
                     s_brw_c ? dn60(time_q[15:8]) : time_q[15:8],
                     dn60(time_q[7:0])};

  assign adj_src = (mode == MODE_ALSET) ? alarm_reg_q : time_q;
  assign adj_res = {e_hou ? inc_hour(adj_src[23:16]) : adj_src[23:16],
                    e_min ? wrap60(adj_src[15:8])    : adj_src[15:8],
                    e_sec ? wrap60(adj_src[7:0])     : adj_src[7:0]};

  // Next-state logic for counting, adjust, run control, flags and blink phase.
  always_comb begin
    sync1_d     = btn;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    mode_d      = mode;
    time_d      = time_q;
    alarm_reg_d = alarm_reg_q;
    run_d       = run_q;
    match_c     = 1'b0;
    hit_zero_c  = 1'b0;
    tick_cnt_d  = '0;
    blink_cnt_d = '0;
    blink_off_d = 1'b0;

    if (run_q) tick_cnt_d = tick_c ? '0 : tick_cnt_q + TW'(1);

    if (tick_c) begin
      if (mode == MODE_CLOCK || mode == MODE_STOPW) begin
        time_d  = up_time;
        match_c = (mode == MODE_CLOCK) && (up_time == alarm_reg_q);
      end else if (mode == MODE_DOWN && !time_zero_c) begin
        time_d     = dn_time;
        hit_zero_c = (dn_time == 24'h0);
      end
    end

    // Stopwatch seconds button doubles as a reset of the whole time.
    if (adj_ok_c) begin
      if (mode == MODE_STOPW && e_sec) time_d = 24'h0;
      else if (mode == MODE_ALSET)     alarm_reg_d = adj_res;
      else                             time_d = adj_res;
    end

    if (e_start && !(mode == MODE_DOWN && time_zero_c)) run_d = 1'b1;
    if (e_pause) run_d = 1'b0;
    if (mode_chg_c || mode == MODE_ALSET || hit_zero_c) run_d = 1'b0;

    done_d  = (done_q && !(adj_ok_c || mode_chg_c)) || hit_zero_c;
    alarm_d = (alarm_q && !e_ack) || match_c;

    if (done_q || alarm_q) begin
      blink_off_d = blink_off_q;
      if (blink_cnt_q == BW'(BLINK_DIV - 1)) blink_off_d = ~blink_off_q;
      else                                   blink_cnt_d = blink_cnt_q + BW'(1);
    end
  end

  always_ff @(posedge CLK or negedge clr) begin
    if (!clr) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      mode_q      <= MODE_CLOCK;
      time_q      <= '0;
      alarm_reg_q <= '0;
      run_q       <= 1'b0;
      alarm_q     <= 1'b0;
      done_q      <= 1'b0;
      tick_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      mode_q      <= mode_d;
      time_q      <= time_d;
      alarm_reg_q <= alarm_reg_d;
      run_q       <= run_d;
      alarm_q     <= alarm_d;
      done_q      <= done_d;
      tick_cnt_q  <= tick_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
    end
  end

  assign timing  = run_q;
  assign alarm   = alarm_q;
  assign done    = done_q;

  assign disp    = (mode_q == MODE_ALSET) ? alarm_reg_q : time_q;
  assign blank_c = (done_q || alarm_q) && blink_off_q;
  assign HEX0    = blank_c ? 7'h7F : seg7(disp[3:0]);
  assign HEX1    = blank_c ? 7'h7F : seg7(disp[7:4]);
  assign HEX2    = blank_c ? 7'h7F : seg7(disp[11:8]);
  assign HEX3    = blank_c ? 7'h7F : seg7(disp[15:12]);
  assign HEX4    = blank_c ? 7'h7F : seg7(disp[19:16]);
  assign HEX5    = blank_c ? 7'h7F : seg7(disp[23:20]);

endmodule
